// File: rtl/sec_loc_search.sv
// Single-error location search for an AN-coded word: walks +/-2^(k-1) mod A
// against the received remainder until a match, a trivial syndrome, or NLOC.
module sec_loc_search #(
    parameter int A    = 18613,
    parameter int NLOC = 45,
    parameter int RW   = 15,
    parameter int LW   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [RW-1:0]        syn,
    output logic                 busy,
    output logic                 done,
    output logic signed [LW-1:0] loc,
    output logic                 err,
    output logic                 unc
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam int            KW = $clog2(NLOC + 1);
    localparam logic [RW:0]   AW = (RW + 1)'(A);
    localparam logic [KW-1:0] KMAX = KW'(NLOC);

    state_t               state, state_nxt;
    logic [RW-1:0]        syn_q;
    logic [RW-1:0]        p;
    logic [KW-1:0]        k;
    logic [RW:0]          p_dbl, p_red, a_minus_p;
    logic signed [LW-1:0] kl;
    logic                 out_big, out_zero, hit_pos, hit_neg, hit_end, found;

    // Doubling keeps the carry bit so the reduction compare sees the full 2p.
    assign p_dbl     = {p, 1'b0};
    assign p_red     = (p_dbl >= AW) ? (p_dbl - AW) : p_dbl;
    assign a_minus_p = AW - {1'b0, p};
    assign kl        = LW'(k);

    assign out_big  = ({1'b0, syn_q} >= AW);
    assign out_zero = (syn_q == '0);
    assign hit_pos  = (p == syn_q);
    assign hit_neg  = (a_minus_p == {1'b0, syn_q});
    assign hit_end  = (k == KMAX);
    assign found    = out_big | out_zero | hit_pos | hit_neg | hit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEARCH;
            SEARCH:  if (found) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_q <= '0;
            p     <= '0;
            k     <= '0;
            loc   <= '0;
            err   <= 1'b0;
            unc   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                syn_q <= syn;
                p     <= RW'(1);
                k     <= KW'(1);
                loc   <= '0;
                err   <= 1'b0;
                unc   <= 1'b0;
            end
        end else if (state == SEARCH) begin
            // Priority order matters: invalid and zero syndromes win over any match.
            if (out_big) begin
                unc <= 1'b1;
                loc <= '0;
            end else if (out_zero) begin
                err <= 1'b0;
                unc <= 1'b0;
                loc <= '0;
            end else if (hit_pos) begin
                err <= 1'b1;
                loc <= kl;
            end else if (hit_neg) begin
                err <= 1'b1;
                loc <= -kl;
            end else if (hit_end) begin
                unc <= 1'b1;
                loc <= '0;
            end else begin
                k <= k + KW'(1);
                p <= p_red[RW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sec_loc_search.sv
// Directed bench for sec_loc_search: latency, location sign/magnitude,
// busy-start rejection, DONE-cycle start rejection and mid-search reset.
module tb_sec_loc_search;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [14:0]       syn;
    logic              busy;
    logic              done;
    logic signed [6:0] loc;
    logic              err;
    logic              unc;

    int checks = 0;
    int errors = 0;

    sec_loc_search #(.A(18613), .NLOC(45), .RW(15), .LW(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .syn(syn),
        .busy(busy), .done(done), .loc(loc), .err(err), .unc(unc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits up to budget edges for done; n returns the edge count (0 if none).
    task automatic wait_done(input int n0, input int budget, output int n);
        int c;
        c = n0;
        n = 0;
        while (n == 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
            if (done) n = c;
        end
    endtask

    task automatic run(input string tag, input int s, input int lat,
                       input int eloc, input int eerr, input int eunc);
        int n;
        @(negedge clk);
        start = 1'b1;
        syn   = 15'(s);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, int'(busy), 1);
        wait_done(0, 100, n);
        check({tag, ".lat"}, n, lat);
        check({tag, ".loc"}, int'(loc), eloc);
        check({tag, ".err"}, int'(err), eerr);
        check({tag, ".unc"}, int'(unc), eunc);
        @(posedge clk); #1;
        check({tag, ".done_1cyc"}, int'(done), 0);
        check({tag, ".idle"}, int'(busy), 0);
        check({tag, ".hold_loc"}, int'(loc), eloc);
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        syn   = '0;
        #12;
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.loc",  int'(loc),  0);
        check("rst.err",  int'(err),  0);
        check("rst.unc",  int'(unc),  0);
        @(negedge clk);
        rst_n = 1'b1;

        run("pos1",   1,     1,   1, 1, 0);
        run("neg1",   18612, 1,  -1, 1, 0);
        run("pos45",  3623,  45, 45, 1, 0);
        run("neg45",  14990, 45, -45, 1, 0);
        run("pos16",  14155, 16, 16, 1, 0);
        run("zero",   0,     1,   0, 0, 0);
        run("big",    18613, 1,   0, 0, 1);
        run("nomatch", 5,    45,  0, 0, 1);

        // Start while busy is ignored; start in the DONE cycle is ignored too.
        @(negedge clk);
        start = 1'b1;
        syn   = 15'd3623;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        syn   = 15'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("busyign.busy", int'(busy), 1);
        wait_done(3, 100, n);
        check("busyign.lat", n, 45);
        check("busyign.loc", int'(loc), 45);
        check("busyign.err", int'(err), 1);
        start = 1'b1;
        syn   = 15'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("doneign.busy", int'(busy), 0);
        check("doneign.loc",  int'(loc), 45);
        run("after", 2, 2, 2, 1, 0);

        // Reset mid-search aborts with no done pulse.
        @(negedge clk);
        start = 1'b1;
        syn   = 15'd5;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.busy", int'(busy), 0);
        check("midrst.done", int'(done), 0);
        check("midrst.loc",  int'(loc),  0);
        check("midrst.err",  int'(err),  0);
        check("midrst.unc",  int'(unc),  0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("midrst.nodone", int'(seen), 0);
        run("postrst", 18612, 1, -1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
